neuron_integrator: RTL

Leaky integrate-and-fire stage that sits directly downstream of `neuron`. It consumes the stream of signed 32-bit weighted products that `neuron` produces and accumulates them into a membrane potential, one beat per cycle. At the end of each timestep it applies a shift-based leak, compares the result against a threshold, and emits one spike/no-spike result through a valid/ready handshake.

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/neuron_integrator_sat_addsub.sv | 33 +++
 rtl/neuron_integrator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the leaky integrate-and-fire stage.
package neuron_pkg;

   localparam int DATA_W         = 32;
   localparam int MAX_BEATS_DEF  = 16;
   localparam int LEAK_SHIFT_DEF = 4;

   // Beat counter width; the counter never needs to hold MAX_BEATS itself
   // because the beat at count MAX_BEATS-1 ends the timestep.
   localparam int CNT_W = $clog2(MAX_BEATS_DEF);

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      LEAK  = 2'd1,
      OUT   = 2'd2
   } integ_state_t;

endpackage

// File: rtl/neuron_integrator_sat_addsub.sv
// Combinational signed add/subtract that clamps instead of wrapping.
module sat_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y
);

   localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] ext;
   logic           ovf;

   // One guard bit: overflow shows up as the guard and top bits disagreeing,
   // and the guard bit then carries the true sign of the result.
   always_comb begin
      if (sub) begin
         ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      end else begin
         ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      end
      ovf = ext[WIDTH] ^ ext[WIDTH-1];
      if (ovf) begin
         y = ext[WIDTH] ? MIN_V : MAX_V;
      end else begin
         y = ext[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/neuron_integrator.sv
// Leaky integrate-and-fire stage: accumulates signed products per timestep,
// applies a shift leak, compares to threshold and hands out one result.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   ACCUM | accepting products, potential += product (saturating)
//   LEAK  | one cycle: apply leak, compare, register spike/potential_out
//   OUT   | result presented on spike_valid until spike_ready
module neuron_integrator
   import neuron_pkg::*;
#(
   parameter int WIDTH      = DATA_W,
   parameter int MAX_BEATS  = MAX_BEATS_DEF,
   parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [WIDTH-1:0] threshold,
   output logic             spike_valid,
   input  logic             spike_ready,
   output logic             spike,
   output logic [WIDTH-1:0] potential_out
);

   integ_state_t state, state_nxt;

   logic signed [WIDTH-1:0] potential;
   logic        [WIDTH-1:0] sum;
   logic        [WIDTH-1:0] leak_amt;
   logic        [WIDTH-1:0] leaked;
   logic        [CNT_W-1:0] beat_cnt;
   logic                    accept;
   logic                    end_beat;
   logic                    fire;

   assign accept   = in_valid & in_ready;
   assign end_beat = in_last | (beat_cnt == CNT_W'(MAX_BEATS - 1));
   assign fire     = $signed(leaked) >= $signed(threshold);

   // Leak amount; a zero shift must mean no leak, not p - p.
   always_comb begin
      leak_amt = '0;
      if (LEAK_SHIFT != 0) begin
         leak_amt = potential >>> LEAK_SHIFT;
      end
   end

   sat_addsub #(.WIDTH(WIDTH)) u_add (
      .a   (potential),
      .b   (in_data),
      .sub (1'b0),
      .y   (sum)
   );

   sat_addsub #(.WIDTH(WIDTH)) u_leak (
      .a   (potential),
      .b   (leak_amt),
      .sub (1'b1),
      .y   (leaked)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      spike_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (accept && end_beat) begin
               state_nxt = LEAK;
            end
         end
         LEAK: begin
            state_nxt = OUT;
         end
         OUT: begin
            spike_valid = 1'b1;
            if (spike_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   // Potential, beat counter and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         potential     <= '0;
         beat_cnt      <= '0;
         spike         <= 1'b0;
         potential_out <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  potential <= sum;
                  beat_cnt  <= beat_cnt + 1'b1;
               end
            end
            LEAK: begin
               spike         <= fire;
               potential_out <= leaked;
               potential     <= fire ? '0 : leaked;
               beat_cnt      <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
